// File: rtl/product_accum.sv
// Unsigned product accumulator: sums a burst of products and holds the total for a consumer.
// Optional build macro ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module product_accum #(
  parameter int PW = 16,
  parameter int AW = 24,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_acc,
  output logic [CW-1:0] out_count,
  output logic          out_ovf
);

  localparam logic [0:0] ACC  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] acc_p1;
  logic [CW-1:0] count_p1;
  logic          ovf_p1;
  logic          vld_p0;
  logic [AW:0]   sum_p0;

  // Returns {carry, next_acc}; the carry drives the sticky overflow flag.
  function automatic logic [AW:0] acc_add(input logic [AW-1:0] a, input logic [PW-1:0] p);
    logic [AW:0] s;
    s = {1'b0, a} + {{(AW+1-PW){1'b0}}, p};
`ifdef ACC_SAT_EN
    if (s[AW]) s[AW-1:0] = {AW{1'b1}};
`else
    s = s;
`endif
    return s;
  endfunction

  function automatic logic [CW-1:0] count_inc(input logic [CW-1:0] c);
    if (&c) return c;
    return c + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  assign in_ready  = (state == ACC)  & ~rst & ~clr;
  assign out_valid = (state == HOLD) & ~rst & ~clr;
  assign vld_p0    = in_valid & in_ready;
  assign sum_p0    = acc_add(acc_p1, in_prod);

  // p0 -> p1: accepted beat folded into the running registers
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state    <= ACC;
      acc_p1   <= '0;
      count_p1 <= '0;
      ovf_p1   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (vld_p0) begin
            acc_p1   <= sum_p0[AW-1:0];
            ovf_p1   <= ovf_p1 | sum_p0[AW];
            count_p1 <= count_inc(count_p1);
            if (in_last) state <= HOLD;
          end
        end
        default: begin
          if (out_ready) begin
            acc_p1   <= '0;
            count_p1 <= '0;
            ovf_p1   <= 1'b0;
            state    <= ACC;
          end
        end
      endcase
    end
  end

  assign out_acc   = acc_p1;
  assign out_count = count_p1;
  assign out_ovf   = ovf_p1;

endmodule

// File: tb/tb_product_accum.sv
// Scoreboard bench for product_accum: default instance plus a CW=4 instance for count saturation.
module tb_product_accum;

  typedef struct {
    logic [23:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  res_t sb[$];
  int tests = 0;
  int fails = 0;

  logic        clk = 0;
  logic        rst = 1, clr = 0;
  logic        in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] in_prod = 0;
  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_acc;
  logic [7:0]  out_count;

  logic        clr2 = 0, in2_valid = 0, in2_last = 0, out2_ready = 0;
  logic [15:0] in2_prod = 0;
  logic        in2_ready, out2_valid, out2_ovf;
  logic [23:0] out2_acc;
  logic [3:0]  out2_count;

  always #5 clk = ~clk;

  product_accum dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  product_accum #(.PW(16), .AW(24), .CW(4)) dut2 (
    .clk(clk), .rst(rst), .clr(clr2),
    .in_valid(in2_valid), .in_ready(in2_ready), .in_prod(in2_prod), .in_last(in2_last),
    .out_valid(out2_valid), .out_ready(out2_ready),
    .out_acc(out2_acc), .out_count(out2_count), .out_ovf(out2_ovf)
  );

  task automatic send_beat(input logic [15:0] p, input logic l);
    in_valid = 1; in_prod = p; in_last = l;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (out_valid === 1'b1) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_hs: in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
    end
    @(posedge clk); @(negedge clk);
    tests++;
    if (out_acc !== 24'h0 || out_count !== 8'h0 || out_ovf !== 1'b0 || out2_count !== 4'h0) begin
      fails++; $display("FAIL reset_vals: acc=%h cnt=%h ovf=%b required 0", out_acc, out_count, out_ovf);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    bit ok;
    res_t e;
    sb.push_back('{acc: 24'h000107, cnt: 8'd3, ovf: 1'b0});
    send_beat(16'h0003, 0);
    send_beat(16'h0005, 0);
    send_beat(16'h00FF, 1);
    wait_valid(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_timeout: out_valid never rose"); end
    e = sb.pop_front();
    // Unaccepted beats with in_last during HOLD must be ignored.
    in_valid = 1; in_prod = 16'h0099; in_last = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== e.acc ||
          out_count !== e.cnt || out_ovf !== e.ovf) begin
        fails++;
        $display("FAIL basic_hold[%0d]: v=%b rdy=%b acc=%h cnt=%0d ovf=%b required 1/0/%h/%0d/%b",
                 i, out_valid, in_ready, out_acc, out_count, out_ovf, e.acc, e.cnt, e.ovf);
      end
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 24'h0 || out_count !== 8'h0) begin
      fails++; $display("FAIL basic_release: v=%b rdy=%b acc=%h cnt=%0d required 0/1/0/0",
                        out_valid, in_ready, out_acc, out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] p[3] = '{16'hFFFF, 16'h0001, 16'h0001};
    logic        l[3] = '{1'b1, 1'b0, 1'b1};
    int idx = 0, lows = 0, got = 0;
    bit acc_now;
    res_t e;
    sb.push_back('{acc: 24'h00FFFF, cnt: 8'd1, ovf: 1'b0});
    sb.push_back('{acc: 24'h000002, cnt: 8'd2, ovf: 1'b0});
    out_ready = 1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (idx < 3) begin in_valid = 1; in_prod = p[idx]; in_last = l[idx]; end
      else begin in_valid = 0; in_last = 0; end
      @(negedge clk);
      acc_now = in_valid & in_ready;
      if (!in_ready) lows++;
      if (out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL b2b_extra: unexpected result acc=%h", out_acc);
        end else begin
          e = sb.pop_front();
          got++;
          if (out_acc !== e.acc || out_count !== e.cnt || out_ovf !== e.ovf) begin
            fails++; $display("FAIL b2b_result: acc=%h cnt=%0d ovf=%b required %h/%0d/%b",
                              out_acc, out_count, out_ovf, e.acc, e.cnt, e.ovf);
          end
        end
      end
      @(posedge clk); #1;
      if (acc_now) idx++;
    end
    in_valid = 0; in_last = 0; out_ready = 0;
    tests++;
    if (got != 2 || lows != 2) begin
      fails++; $display("FAIL b2b_bubbles: results=%0d bubbles=%0d required 2/2", got, lows);
    end
  endtask

  task automatic test_overflow;
    bit ok;
    res_t e;
`ifdef ACC_SAT_EN
    sb.push_back('{acc: 24'hFFFFFF, cnt: 8'd255, ovf: 1'b1});
`else
    sb.push_back('{acc: 24'h00FEFF, cnt: 8'd255, ovf: 1'b1});
`endif
    for (int i = 0; i < 257; i++) send_beat(16'hFFFF, i == 256);
    wait_valid(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || out_acc !== e.acc || out_count !== e.cnt || out_ovf !== e.ovf) begin
      fails++; $display("FAIL overflow: v=%b acc=%h cnt=%0d ovf=%b required 1/%h/%0d/%b",
                        out_valid, out_acc, out_count, out_ovf, e.acc, e.cnt, e.ovf);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_count_sat;
    res_t e;
    bit ok = 0;
    sb.push_back('{acc: 24'h000014, cnt: 8'd15, ovf: 1'b0});
    for (int i = 0; i < 20; i++) begin
      in2_valid = 1; in2_prod = 16'h0001; in2_last = (i == 19);
      @(posedge clk); #1;
    end
    in2_valid = 0; in2_last = 0;
    for (int i = 0; i < 20; i++) begin
      if (out2_valid === 1'b1) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    tests++;
    if (!ok || out2_acc !== e.acc || out2_count !== e.cnt[3:0] || out2_ovf !== e.ovf) begin
      fails++; $display("FAIL count_sat: v=%b acc=%h cnt=%0d ovf=%b required 1/%h/%0d/%b",
                        out2_valid, out2_acc, out2_count, out2_ovf, e.acc, e.cnt, e.ovf);
    end
    out2_ready = 1;
    @(posedge clk); #1;
    out2_ready = 0;
  endtask

  task automatic test_clr;
    bit ok;
    res_t e;
    send_beat(16'h0010, 0);
    send_beat(16'h0020, 0);
    clr = 1; in_valid = 1; in_prod = 16'h0040; in_last = 0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL clr_force: in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    clr = 0; in_valid = 0;
    @(negedge clk);
    tests++;
    if (out_acc !== 24'h0 || out_count !== 8'h0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL clr_state: acc=%h cnt=%0d rdy=%b required 0/0/1", out_acc, out_count, in_ready);
    end
    @(posedge clk); #1;
    sb.push_back('{acc: 24'h000007, cnt: 8'd1, ovf: 1'b0});
    send_beat(16'h0007, 1);
    wait_valid(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || out_acc !== e.acc || out_count !== e.cnt || out_ovf !== e.ovf) begin
      fails++; $display("FAIL clr_burst: v=%b acc=%h cnt=%0d ovf=%b required 1/%h/%0d/%b",
                        out_valid, out_acc, out_count, out_ovf, e.acc, e.cnt, e.ovf);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_rst_hold;
    bit ok;
    send_beat(16'h0055, 1);
    wait_valid(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rsthold_timeout: out_valid never rose"); end
    rst = 1; out_ready = 1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL rsthold_force: v=%b rdy=%b required 0/0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst = 0; out_ready = 0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 24'h0 ||
        out_count !== 8'h0 || out_ovf !== 1'b0) begin
      fails++; $display("FAIL rsthold_after: v=%b rdy=%b acc=%h cnt=%0d ovf=%b required 0/1/0/0/0",
                        out_valid, in_ready, out_acc, out_count, out_ovf);
    end
    @(posedge clk); #1;
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_count_sat();
    test_clr();
    test_rst_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
